// File: rtl/aes_encrypt.sv
// Iterative AES-128 encryption core: one round per clock,
// round keys expanded on the fly from the stored cipher key.

module aes_sbox (
    input  logic [7:0] x,
    output logic [7:0] y
);
    localparam logic [7:0] TABLE [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y = TABLE[x];
endmodule

module aes_encrypt (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic [127:0] Key,
    input  logic         Keyrdy,
    input  logic [127:0] Din,
    input  logic         Datardy,
    output logic [127:0] Dout,
    output logic         BSY,
    output logic         Dvld
);
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    logic [127:0] state;
    logic [127:0] keyreg;
    logic [127:0] rk;
    logic [7:0]   rcon;
    logic [3:0]   round;

    logic [127:0] sb;
    logic [127:0] sr;
    logic [127:0] mc;
    logic [127:0] rk_next;
    logic [127:0] state_next;
    logic         last;

    genvar i, r;

    // Byte b of the state sits at bits [127-8b -: 8], column-major.
    for (i = 0; i < 16; i++) begin : g_sub
        aes_sbox u_sbox (
            .x(state[127-8*i -: 8]),
            .y(sb[127-8*i -: 8])
        );
    end

    for (i = 0; i < 4; i++) begin : g_col
        for (r = 0; r < 4; r++) begin : g_row
            assign sr[127-8*(4*i+r) -: 8] =
                sb[127-8*(4*((i+r)%4)+r) -: 8];
        end
        assign mc[127-32*i -: 32] = mix_col(sr[127-32*i -: 32]);
    end

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, sub, tmp;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = rk;
    assign rot = {w3[23:0], w3[31:24]};

    for (i = 0; i < 4; i++) begin : g_key
        aes_sbox u_sbox (
            .x(rot[31-8*i -: 8]),
            .y(sub[31-8*i -: 8])
        );
    end

    assign tmp = sub ^ {rcon, 24'h000000};
    assign n0  = w0 ^ tmp;
    assign n1  = w1 ^ n0;
    assign n2  = w2 ^ n1;
    assign n3  = w3 ^ n2;
    assign rk_next = {n0, n1, n2, n3};

    assign last       = (round == 4'd10);
    assign state_next = (last ? sr : mc) ^ rk_next;

    always_ff @(posedge CLK) begin
        if (RST) begin
            Dout   <= '0;
            keyreg <= '0;
            state  <= '0;
            rk     <= '0;
            rcon   <= 8'h01;
            round  <= '0;
            BSY    <= 1'b0;
            Dvld   <= 1'b0;
        end else begin
            Dvld <= 1'b0;
            if (EN) begin
                if (!BSY) begin
                    if (Keyrdy) begin
                        keyreg <= Key;
                    end else if (Datardy) begin
                        state <= Din ^ keyreg;
                        rk    <= keyreg;
                        rcon  <= 8'h01;
                        round <= 4'd1;
                        BSY   <= 1'b1;
                    end
                end else begin
                    state <= state_next;
                    rk    <= rk_next;
                    rcon  <= xtime(rcon);
                    round <= round + 4'd1;
                    if (last) begin
                        Dout <= state_next;
                        Dvld <= 1'b1;
                        BSY  <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_aes_encrypt.sv
// Randomised scoreboard bench for aes_encrypt against a
// byte-array AES-128 reference built from GF(2^8) arithmetic.

module tb_aes_encrypt;
    logic         clk;
    logic         rst;
    logic         en;
    logic         keyrdy;
    logic         datardy;
    logic [127:0] key;
    logic [127:0] din;
    logic [127:0] dout;
    logic         bsy;
    logic         dvld;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [127:0] data;
        int           due;
    } exp_t;

    exp_t         q[$];
    logic [7:0]   sbox_t [256];
    logic [127:0] model_key;

    aes_encrypt dut (
        .CLK(clk),
        .RST(rst),
        .EN(en),
        .Key(key),
        .Keyrdy(keyrdy),
        .Din(din),
        .Datardy(datardy),
        .Dout(dout),
        .BSY(bsy),
        .Dvld(dvld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [8:0] t;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ a;
            t = {a, 1'b0};
            if (t[8]) t = t ^ 9'h11b;
            a = t[7:0];
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Multiplicative inverse in GF(2^8) followed by the affine map.
    function automatic logic [7:0] sbox_math(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h00;
        if (a != 8'h00) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, a);
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
             ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] k,
                                             input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tw;
        logic [7:0]   rc;
        logic [127:0] ct;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tw = w[i-1];
            if (i % 4 == 0) begin
                tw = {tw[23:0], tw[31:24]};
                tw = {sbox_t[tw[31:24]], sbox_t[tw[23:16]],
                      sbox_t[tw[15:8]], sbox_t[tw[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tw;
        end
        for (int i = 0; i < 16; i++)
            s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r+4*c] = s[r+4*((c+r)%4)];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r+4*c] = (rnd == 10) ? t[r+4*c] :
                        gmul(t[4*c+r], 8'h02)
                        ^ gmul(t[4*c+(r+1)%4], 8'h03)
                        ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
            for (int i = 0; i < 16; i++)
                s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
        return ct;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_block(input logic [127:0] d,
                               input logic [127:0] exp, input int extra);
        exp_t e;
        din = d;
        datardy = 1'b1;
        tick();
        datardy = 1'b0;
        e.data = exp;
        e.due = cyc + 10 + extra;
        q.push_back(e);
    endtask

    task automatic load_key(input logic [127:0] k);
        key = k;
        keyrdy = 1'b1;
        tick();
        keyrdy = 1'b0;
        model_key = k;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        if (q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain_timeout: %0d blocks pending after %0d cycles, expected 0",
                     q.size(), n);
            q.delete();
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (dvld === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_dvld: Dvld at cycle %0d Dout=%h, expected no output",
                         cyc, dout);
            end else begin
                e = q.pop_front();
                if (dout !== e.data || cyc != e.due) begin
                    errors++;
                    $display("FAIL dout_check: got %h at cycle %0d, expected %h at cycle %0d",
                             dout, cyc, e.data, e.due);
                end
            end
        end
    end

    initial begin
        logic [127:0] d;
        logic [127:0] pt;
        logic [127:0] ct;
        for (int v = 0; v < 256; v++) sbox_t[v] = sbox_math(8'(v));

        rst = 1'b1;
        en = 1'($urandom);
        keyrdy = 1'($urandom);
        datardy = 1'($urandom);
        key = rand128();
        din = rand128();
        tick();
        tick();
        chk("reset_dout", dout, 128'h0);
        chk("reset_bsy", {127'h0, bsy}, 128'h0);
        chk("reset_dvld", {127'h0, dvld}, 128'h0);
        rst = 1'b0;
        en = 1'b1;
        keyrdy = 1'b0;
        datardy = 1'b0;
        model_key = '0;

        pt = 128'h00112233445566778899aabbccddeeff;
        ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        load_key(128'h000102030405060708090a0b0c0d0e0f);
        start_block(pt, ct, 0);
        for (int k = 0; k < 10; k++) begin
            chk("c1_bsy_high", {127'h0, bsy}, 128'h1);
            tick();
        end
        chk("c1_bsy_low", {127'h0, bsy}, 128'h0);
        chk("c1_dvld_edge", {127'h0, dvld}, 128'h1);

        start_block(pt, ct, 0);
        tick();
        tick();
        din = rand128();
        datardy = 1'b1;
        key = rand128();
        keyrdy = 1'b1;
        tick();
        datardy = 1'b0;
        keyrdy = 1'b0;
        drain();

        en = 1'b0;
        keyrdy = 1'b1;
        datardy = 1'b1;
        key = rand128();
        din = rand128();
        tick();
        tick();
        chk("en_low_no_bsy", {127'h0, bsy}, 128'h0);
        keyrdy = 1'b0;
        datardy = 1'b0;
        en = 1'b1;
        d = rand128();
        start_block(d, aes_ref(model_key, d), 0);
        drain();

        d = rand128();
        start_block(d, aes_ref(model_key, d), 3);
        repeat (3) tick();
        en = 1'b0;
        repeat (3) tick();
        chk("en_gap_bsy_frozen", {127'h0, bsy}, 128'h1);
        en = 1'b1;
        drain();

        key = rand128();
        din = rand128();
        keyrdy = 1'b1;
        datardy = 1'b1;
        tick();
        model_key = key;
        keyrdy = 1'b0;
        datardy = 1'b0;
        tick();
        chk("priority_no_block", {127'h0, bsy}, 128'h0);
        d = rand128();
        start_block(d, aes_ref(model_key, d), 0);
        drain();

        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 2) == 0) load_key(rand128());
            d = rand128();
            start_block(d, aes_ref(model_key, d), 0);
            drain();
        end

        din = rand128();
        datardy = 1'b1;
        tick();
        datardy = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk("midreset_bsy", {127'h0, bsy}, 128'h0);
        chk("midreset_dout", dout, 128'h0);
        chk("midreset_dvld", {127'h0, dvld}, 128'h0);
        rst = 1'b0;
        repeat (15) tick();
        model_key = '0;
        d = rand128();
        start_block(d, aes_ref(model_key, d), 0);
        drain();

        chk("queue_empty", 128'(q.size()), 128'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/aes_encrypt.md
Name: aes_encrypt

Overview:
- Iterative AES-128 encryption core: one round per clock, with round keys generated on the fly from a stored 128-bit cipher key.
- Sits beside a matching decryption core on a shared Din/Key bus; a per-core EN selects which core is active.
- Simple ready/valid handshake: Keyrdy loads a key, Datardy starts a block, BSY reports busy, Dvld marks a finished block.

Parameters:
- None. Key size is fixed at 128 bits and round count at 10.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset, synchronous and active-high.
- EN  input  1  core enable; when low, Keyrdy and Datardy are ignored and all state holds.
- Key  input  128  cipher key, sampled when Keyrdy is accepted.
- Keyrdy  input  1  key-load strobe.
- Din  input  128  plaintext block, sampled when Datardy is accepted.
- Datardy  input  1  start-of-block strobe.
- Dout  output  128  ciphertext; registered, holds its value until the next block completes.
- BSY  output  1  high while the core is encrypting.
- Dvld  output  1  one-cycle pulse when Dout updates.

Behaviour:
- Byte order follows FIPS-197: bits [127:120] are byte 0, and bytes fill the state column-major.
- Reset (RST=1 at a clock edge) clears Dout, the key register, the state register, round-key register, round counter, BSY and Dvld to 0, and puts the Rcon register at 0x01. Reset overrides everything, including a block in progress.
- Key load, when EN=1, Keyrdy=1 and BSY=0:
  - Key goes into the key register.
  - Keyrdy has priority: a Datardy in the same cycle is dropped.
  - Keyrdy while BSY=1 is ignored.
- Block start, when EN=1, Datardy=1, Keyrdy=0 and BSY=0:
  - state <= Din XOR keyreg (round 0).
  - Round-key register <= keyreg; Rcon <= 0x01; round counter <= 1; BSY <= 1 from the next cycle.
  - Datardy while BSY=1 is ignored.
- Rounds 1..10, one per cycle while BSY=1 and EN=1:
  - The next round key is derived combinationally from the round-key register: RotWord, SubWord, XOR Rcon, then the chained word XORs.
  - The state applies SubBytes, ShiftRows, MixColumns (MixColumns skipped in round 10), then AddRoundKey with that next key.
  - The round-key register takes the next key. Rcon takes xtime(Rcon), so 0x1b follows 0x80.
  - The round counter increments.
- Completion, on round 10:
  - Dout <= the final state; Dvld <= 1 for exactly one cycle; BSY <= 0 in the same edge.
  - Acceptance to Dvld: the Datardy edge at cycle t gives Dvld=1 and valid Dout after edge t+10.
  - A new Datardy is accepted on the cycle after Dvld (back-to-back blocks allowed).
- The key register is never modified by encryption, so repeated blocks reuse the loaded key without reloading.
- EN=0 mid-block: state, counter, round key and BSY freeze, Dvld is forced to 0, and encryption resumes when EN returns to 1.
- Datardy before any key load encrypts with the all-zero key; this is not an error.
- S-box is combinational, 20 instances: 16 for state bytes and 4 for the key schedule. The implementation may be a case table or composite-field inversion, but it must be bit-exact with FIPS-197.
- No inverse cipher is in this block; decryption is a separate core.

Test Plan:
- Reset: hold RST=1 for 2 cycles with random inputs -> Dout=0, BSY=0, Dvld=0.
- FIPS-197 C.1:
  - Load Key=000102030405060708090a0b0c0d0e0f with EN=1 for 1 cycle.
  - Next cycle, Din=00112233445566778899aabbccddeeff with Datardy pulsed 1 cycle.
  - Required: BSY high for 10 cycles; Dvld pulses exactly 10 edges after acceptance; Dout=69c4e0d86a7b0430d8cdb78070b4c55a.
- Key retention and back-to-back:
  - Send the same Din again on the cycle after Dvld, with no key reload -> identical ciphertext 10 cycles later.
  - Datardy pulsed while BSY=1 -> ignored; no extra Dvld.
- Enable gating:
  - With EN=0, pulse Keyrdy/Datardy -> no BSY and no key change.
  - Drop EN for 3 cycles mid-block -> Dvld is delayed by exactly 3 cycles and Dout is still correct.
- Priority and reset mid-operation:
  - Keyrdy and Datardy together -> key loaded, no block started.
  - RST=1 during round 5 -> BSY=0, Dout=0, key cleared, no Dvld afterwards.
